seq_detect_param: RTL and testbench

- Runtime-programmable serial bit-pattern detector; successor to the fixed 4-bit overlapping Moore detector.
- Pattern length is 1..MAX_LEN bits, selectable at run time.
- Overlapping or non-overlapping detection, selectable at run time.
- Sits on a single-bit serial stream with a valid qualifier; provides a registered detect pulse and a saturating match counter for status readback.

---
 rtl/seq_detect_param.sv | 117 +++++++++++
 tb/tb_seq_detect_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Runtime-programmable serial bit-pattern detector. A pattern of 1..MAX_LEN
//   bits is compared against the most recent valid bits of a serial stream.
//   Overlapping or non-overlapping detection is selectable at run time.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous active-high reset, restores default config
//   cfg_load     : latch cfg_pattern/cfg_len/cfg_overlap and clear all state
//   cfg_pattern  : pattern, bit [len-1] is the first bit received
//   cfg_len      : pattern length (values above MAX_LEN clamp to MAX_LEN,
//                  0 disables detection)
//   cfg_overlap  : 1 = overlapping, 0 = non-overlapping
//   in_valid     : qualifies inbits
//   inbits       : serial data bit
//   detect       : registered one-cycle match pulse
//   match_count  : saturating count of matches since reset or cfg_load
//
// Handshake: in_valid has no back-pressure; a bit is consumed on every rising
// edge where in_valid=1 and cfg_load=0. cfg_load wins over in_valid and the
// bit offered in that cycle is dropped.
// ---------------------------------------------------------------------------
module seq_detect_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
   parameter int                 DEF_LEN     = 4,
   parameter bit                 DEF_OVERLAP = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               inbits,
   output logic               detect,
   output logic [CNT_W-1:0]   match_count
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic               r_detect;
   logic [CNT_W-1:0]   r_count;

   logic [MAX_LEN-1:0] w_hist_next;
   logic [LEN_W-1:0]   w_fill_inc;
   logic [MAX_LEN-1:0] w_mask;
   logic [LEN_W-1:0]   w_len_clamped;
   logic               w_match;
   logic               w_cnt_sat;

   assign w_hist_next   = {r_hist[MAX_LEN-2:0], inbits};
   assign w_fill_inc    = (r_fill >= MAX_LEN_L) ? r_fill : r_fill + LEN_W'(1);
   assign w_len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
   assign w_cnt_sat     = &r_count;

   // Only the low r_len bits of history and pattern take part in the compare.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
   end

   // Match is judged on the history after the new bit is shifted in; fill
   // guarantees every compared bit arrived since the last clear.
   assign w_match = (r_len != '0) &&
                    (w_fill_inc >= r_len) &&
                    (((w_hist_next ^ r_pattern) & w_mask) == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pattern <= DEF_PATTERN;
         r_len     <= LEN_W'(DEF_LEN);
         r_overlap <= DEF_OVERLAP;
         r_hist    <= '0;
         r_fill    <= '0;
         r_detect  <= 1'b0;
         r_count   <= '0;
      end else if (cfg_load) begin
         r_pattern <= cfg_pattern;
         r_len     <= w_len_clamped;
         r_overlap <= cfg_overlap;
         r_hist    <= '0;
         r_fill    <= '0;
         r_detect  <= 1'b0;
         r_count   <= '0;
      end else if (in_valid) begin
         r_hist   <= w_hist_next;
         r_detect <= w_match;
         if (w_match) begin
            if (!w_cnt_sat) begin
               r_count <= r_count + CNT_W'(1);
            end
            // Non-overlapping: the next match must be built from fresh bits.
            r_fill <= r_overlap ? w_fill_inc : '0;
         end else begin
            r_fill <= w_fill_inc;
         end
      end else begin
         r_detect <= 1'b0;
      end
   end

   assign detect      = r_detect;
   assign match_count = r_count;

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
//   Directed bench for seq_detect_param. A bit-list model predicts detect and
//   match_count for every driven cycle; a compare process checks them on the
//   falling edge. Literal pulse/count totals per scenario pin the model.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 8;
   localparam int W       = CNT_W + 1;

   logic               clk;
   logic               reset;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               inbits;
   logic               detect;
   logic [CNT_W-1:0]   match_count;

   int checks   = 0;
   int failures = 0;
   int total_pulses = 0;

   logic [W-1:0] exp_q[$];

   // model state
   logic           hist_q[$];
   int             m_since;
   int             m_cnt;
   int             m_len;
   logic [7:0]     m_pat;
   logic           m_ov;

   seq_detect_param #(
      .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
      .DEF_PATTERN(8'b0000_1011), .DEF_LEN(4), .DEF_OVERLAP(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .inbits(inbits), .detect(detect), .match_count(match_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // model
   task automatic model_reset();
      hist_q.delete();
      m_since = 0;
      m_cnt   = 0;
      m_len   = 4;
      m_pat   = 8'b0000_1011;
      m_ov    = 1'b1;
   endtask

   task automatic model_step(input logic ld, input logic [7:0] pat,
                             input logic [3:0] len, input logic ov,
                             input logic v, input logic b);
      logic det;
      logic hit;
      det = 1'b0;
      if (ld) begin
         m_pat = pat;
         m_len = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
         m_ov  = ov;
         hist_q.delete();
         m_since = 0;
         m_cnt   = 0;
      end else if (v) begin
         hist_q.push_back(b);
         if (hist_q.size() > MAX_LEN) void'(hist_q.pop_front());
         if (m_since < MAX_LEN) m_since++;
         hit = (m_len > 0) && (m_since >= m_len);
         for (int k = 0; k < m_len; k++) begin
            if (hit && hist_q[hist_q.size()-1-k] != m_pat[k]) hit = 1'b0;
         end
         if (hit) begin
            det = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (!m_ov) m_since = 0;
         end
      end
      exp_q.push_back({det, m_cnt[CNT_W-1:0]});
   endtask

   // driver tasks
   task automatic cyc(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                      input logic ov, input logic v, input logic b);
      @(negedge clk);
      cfg_load    = ld;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ov;
      in_valid    = v;
      inbits      = b;
      @(posedge clk);
      model_step(ld, pat, len, ov, v, b);
   endtask

   task automatic bit_in(input logic b);
      cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b);
   endtask

   task automatic gap();
      cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
      cyc(1'b1, pat, len, ov, 1'b0, 1'b0);
   endtask

   task automatic bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
   endtask

   task automatic settle();
      @(negedge clk);
      cfg_load = 1'b0;
      in_valid = 1'b0;
      #1;
   endtask

   // scoreboard: compare every driven cycle on the falling edge
   always @(negedge clk) begin
      if (detect === 1'b1) total_pulses++;
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         check("detect", int'(detect), int'(e[W-1]));
         check("match_count", int'(match_count), int'(e[CNT_W-1:0]));
      end
   end

   int base;

   initial begin
      reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; in_valid = 1'b0; inbits = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_detect", int'(detect), 0);
      check("reset_count", int'(match_count), 0);
      reset = 1'b0;

      // defaults, overlap: 1011011 -> pulses after bits 4 and 7
      base = total_pulses;
      bits(16'b1011011, 7);
      settle();
      check("def_ovl_pulses", total_pulses - base, 2);
      check("def_ovl_count", int'(match_count), 2);

      // non-overlap
      load(8'b0000_1011, 4'd4, 1'b0);
      base = total_pulses;
      bits(16'b1011011, 7);
      settle();
      check("novl_pulses", total_pulses - base, 1);
      check("novl_count", int'(match_count), 1);
      bits(16'b1011, 4);
      settle();
      check("novl_pulses2", total_pulses - base, 2);
      check("novl_count2", int'(match_count), 2);

      // length 8 with gaps between bits 4 and 5
      load(8'hA5, 4'd8, 1'b1);
      base = total_pulses;
      bits(16'b1010, 4);
      gap(); gap(); gap();
      bits(16'b0101, 4);
      settle();
      check("len8_pulses", total_pulses - base, 1);
      check("len8_count", int'(match_count), 1);

      // saturation: len 1, 300 ones
      load(8'h01, 4'd1, 1'b1);
      base = total_pulses;
      for (int i = 0; i < 300; i++) bit_in(1'b1);
      settle();
      check("sat_pulses", total_pulses - base, 300);
      check("sat_count", int'(match_count), 255);

      // cfg_len above MAX_LEN clamps to 8
      load(8'hA5, 4'd12, 1'b1);
      base = total_pulses;
      bits(16'b10100101, 8);
      settle();
      check("clamp_pulses", total_pulses - base, 1);
      check("clamp_count", int'(match_count), 1);

      // cfg_len = 0 disables detection
      load(8'h00, 4'd0, 1'b1);
      base = total_pulses;
      for (int i = 0; i < 20; i++) bit_in(1'($urandom_range(0, 1)));
      settle();
      check("len0_pulses", total_pulses - base, 0);
      check("len0_count", int'(match_count), 0);

      // cfg_load with in_valid: that bit is dropped, so 0,1,1 cannot complete 1011
      base = total_pulses;
      cyc(1'b1, 8'b0000_1011, 4'd4, 1'b0, 1'b1, 1'b1);
      bits(16'b011, 3);
      settle();
      check("loadvalid_pulses", total_pulses - base, 0);
      check("loadvalid_count", int'(match_count), 0);

      // reset mid-operation
      load(8'b0000_1011, 4'd4, 1'b1);
      bits(16'b1011, 4);
      bits(16'b101, 3);
      settle();
      check("pre_reset_count", int'(match_count), 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_detect", int'(detect), 0);
      check("async_reset_count", int'(match_count), 0);
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      base = total_pulses;
      bit_in(1'b1);
      settle();
      check("post_reset_single", total_pulses - base, 0);
      bits(16'b1011, 4);
      settle();
      check("post_reset_pulses", total_pulses - base, 1);
      check("post_reset_count", int'(match_count), 1);

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
